// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: control-unit operation codes and the reset fetch address.
package cpu_pkg;

  typedef enum logic [5:0] {
    CU_NOP   = 6'h00,
    CU_ADD   = 6'h01,
    CU_SUB   = 6'h02,
    CU_AND   = 6'h03,
    CU_OR    = 6'h04,
    CU_XOR   = 6'h05,
    CU_SLL   = 6'h06,
    CU_SRL   = 6'h07,
    CU_SRA   = 6'h08,
    CU_SLT   = 6'h09,
    CU_SLTU  = 6'h0A,
    CU_LUI   = 6'h0B,
    CU_AUIPC = 6'h0C,
    CU_LOAD  = 6'h0D,
    CU_STORE = 6'h0E,
    CU_FENCE = 6'h0F,
    CU_BEQ   = 6'h10,
    CU_BNE   = 6'h11,
    CU_BLT   = 6'h12,
    CU_BGE   = 6'h13,
    CU_BLTU  = 6'h14,
    CU_BGEU  = 6'h15,
    CU_JAL   = 6'h16,
    CU_JALR  = 6'h17,
    CU_ECALL = 6'h18
  } cu_op_t;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'h0000_0004;

  // negative already carries signed/unsigned meaning chosen by the ALU
  function automatic logic branch_taken(input cu_op_t op, input logic zero, input logic negative);
    logic taken;
    case (op)
      CU_BEQ:  taken = zero;
      CU_BNE:  taken = ~zero;
      CU_BLT:  taken = negative;
      CU_BLTU: taken = negative;
      CU_BGE:  taken = ~negative;
      CU_BGEU: taken = ~negative;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_if.sv
// Bundle of the program-counter datapath signals (everything except clock and reset).
interface pc_if;
  import cpu_pkg::*;

  cu_op_t      CUOp;
  logic [31:0] rs1Read;
  logic [31:0] signExtend;
  logic        zero;
  logic        negative;
  logic        iready;
  logic [31:0] PC;
  logic [31:0] nextPC;
  logic [31:0] linkAddr;

  modport pc (
    input  CUOp, rs1Read, signExtend, zero, negative, iready,
    output PC, nextPC, linkAddr
  );

  modport tb (
    output CUOp, rs1Read, signExtend, zero, negative, iready,
    input  PC, nextPC, linkAddr
  );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-fetch-address and link-address selection for the program counter.
module pc_next_logic
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  cu_op_t      cu_op,
  input  logic [31:0] rs1_read,
  input  logic [31:0] sign_extend,
  input  logic        zero,
  input  logic        negative,
  output logic [31:0] next_pc,
  output logic [31:0] link_addr
);

  logic [31:0] seq_pc_s;
  logic [31:0] rel_pc_s;
  logic [31:0] jalr_pc_s;

  assign seq_pc_s  = pc + INSTR_BYTES;
  assign rel_pc_s  = pc + sign_extend;
  assign jalr_pc_s = rs1_read + sign_extend;
  assign link_addr = seq_pc_s;

  // Target select; unknown codes fall through to sequential fetch
  always_comb begin
    next_pc = seq_pc_s;
    case (cu_op)
      CU_JAL:  next_pc = rel_pc_s;
      CU_JALR: next_pc = {jalr_pc_s[31:1], 1'b0};
      CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU: begin
        if (branch_taken(cu_op, zero, negative)) begin
          next_pc = rel_pc_s;
        end else begin
          next_pc = seq_pc_s;
        end
      end
      default: next_pc = seq_pc_s;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter register for the single-cycle RV32I core; advances on instruction-memory ready.
module pc_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  cu_op_t      CUOp,
  input  logic [31:0] rs1Read,
  input  logic [31:0] signExtend,
  input  logic        zero,
  input  logic        negative,
  input  logic        iready,
  output logic [31:0] PC,
  output logic [31:0] nextPC,
  output logic [31:0] linkAddr
);

  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  logic [31:0] link_addr_s;

  pc_next_logic u_next (
    .pc          (pc_r),
    .cu_op       (CUOp),
    .rs1_read    (rs1Read),
    .sign_extend (signExtend),
    .zero        (zero),
    .negative    (negative),
    .next_pc     (next_pc_s),
    .link_addr   (link_addr_s)
  );

  // Fetch-address register: reset name is historical, the level is active-high
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      pc_r <= RESET_PC;
    end else if (iready) begin
      pc_r <= next_pc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign PC       = pc_r;
  assign nextPC   = next_pc_s;
  assign linkAddr = link_addr_s;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: reset, stall, jumps, branches and wrap-around.
module tb_pc_unit;
  import cpu_pkg::*;

  logic tb_clk;
  logic nRST;
  int   n_checks;
  int   n_errors;

  pc_if bus ();

  pc_unit dut (
    .clk        (tb_clk),
    .nRST       (nRST),
    .CUOp       (bus.CUOp),
    .rs1Read    (bus.rs1Read),
    .signExtend (bus.signExtend),
    .zero       (bus.zero),
    .negative   (bus.negative),
    .iready     (bus.iready),
    .PC         (bus.PC),
    .nextPC     (bus.nextPC),
    .linkAddr   (bus.linkAddr)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply(input cu_op_t op, input logic [31:0] rs1, input logic [31:0] imm,
                       input logic z, input logic n, input logic rdy);
    bus.CUOp       = op;
    bus.rs1Read    = rs1;
    bus.signExtend = imm;
    bus.zero       = z;
    bus.negative   = n;
    bus.iready     = rdy;
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // Loads an even absolute address through JALR with a zero offset
  task automatic set_pc(input logic [31:0] addr);
    apply(CU_JALR, addr, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    step();
    check("set_pc", bus.PC, addr);
  endtask

  cu_op_t      br_op  [12];
  logic        br_z   [12];
  logic        br_n   [12];
  logic [31:0] br_exp [12];

  initial begin
    n_checks = 0;
    n_errors = 0;

    br_op[0]  = CU_BEQ;  br_z[0]  = 1'b1; br_n[0]  = 1'b0; br_exp[0]  = 32'h0000_0060;
    br_op[1]  = CU_BEQ;  br_z[1]  = 1'b0; br_n[1]  = 1'b0; br_exp[1]  = 32'h0000_0044;
    br_op[2]  = CU_BNE;  br_z[2]  = 1'b0; br_n[2]  = 1'b0; br_exp[2]  = 32'h0000_0060;
    br_op[3]  = CU_BNE;  br_z[3]  = 1'b1; br_n[3]  = 1'b0; br_exp[3]  = 32'h0000_0044;
    br_op[4]  = CU_BLT;  br_z[4]  = 1'b0; br_n[4]  = 1'b1; br_exp[4]  = 32'h0000_0060;
    br_op[5]  = CU_BLT;  br_z[5]  = 1'b0; br_n[5]  = 1'b0; br_exp[5]  = 32'h0000_0044;
    br_op[6]  = CU_BGE;  br_z[6]  = 1'b0; br_n[6]  = 1'b0; br_exp[6]  = 32'h0000_0060;
    br_op[7]  = CU_BLTU; br_z[7]  = 1'b0; br_n[7]  = 1'b1; br_exp[7]  = 32'h0000_0060;
    br_op[8]  = CU_BGEU; br_z[8]  = 1'b0; br_n[8]  = 1'b1; br_exp[8]  = 32'h0000_0044;
    br_op[9]  = CU_BGEU; br_z[9]  = 1'b1; br_n[9]  = 1'b0; br_exp[9]  = 32'h0000_0060;
    br_op[10] = CU_ADD;  br_z[10] = 1'b1; br_n[10] = 1'b1; br_exp[10] = 32'h0000_0044;
    br_op[11] = cu_op_t'(6'h3F); br_z[11] = 1'b1; br_n[11] = 1'b0; br_exp[11] = 32'h0000_0044;

    // Reset held: PC cleared, combinational outputs follow
    nRST = 1'b1;
    apply(CU_ADD, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge tb_clk);
    check("reset_pc", bus.PC, 32'h0000_0000);
    check("reset_next", bus.nextPC, 32'h0000_0004);
    check("reset_link", bus.linkAddr, 32'h0000_0004);

    nRST = 1'b0;
    step();
    check("step1", bus.PC, 32'h0000_0004);
    step();
    check("step2", bus.PC, 32'h0000_0008);

    // Stall with a jump pending: state must not move
    apply(CU_JAL, 32'h0000_0000, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall", bus.PC, 32'h0000_0008);
    end
    apply(CU_ADD, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    step();
    check("resume", bus.PC, 32'h0000_000C);

    // Asynchronous reset between edges
    #2;
    nRST = 1'b1;
    #1;
    check("async_reset", bus.PC, 32'h0000_0000);
    @(negedge tb_clk);
    nRST = 1'b0;

    set_pc(32'h0000_0100);
    apply(CU_JAL, 32'h0000_0000, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1);
    #1;
    check("jal_link", bus.linkAddr, 32'h0000_0104);
    check("jal_next", bus.nextPC, 32'h0000_00F0);
    step();
    check("jal_pc", bus.PC, 32'h0000_00F0);

    apply(CU_JALR, 32'h0000_2001, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    step();
    check("jalr_bit0", bus.PC, 32'h0000_2010);
    apply(CU_JALR, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    step();
    check("jalr_wrap", bus.PC, 32'h0000_0000);

    for (int i = 0; i < 12; i++) begin
      set_pc(32'h0000_0040);
      apply(br_op[i], 32'h0000_0000, 32'h0000_0020, br_z[i], br_n[i], 1'b1);
      #1;
      check($sformatf("br%0d_next", i), bus.nextPC, br_exp[i]);
      step();
      check($sformatf("br%0d_pc", i), bus.PC, br_exp[i]);
    end

    set_pc(32'hFFFF_FFFC);
    apply(CU_ADD, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    #1;
    check("wrap_link", bus.linkAddr, 32'h0000_0000);
    step();
    check("wrap_pc", bus.PC, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
